// File: rtl/cell_comm_fa_packet_tx.sv
// ============================================================================
// cell_comm_fa_packet_tx : per-FA-cycle BPM frame builder into Aurora AXIS TX.
// Optional macro CELL_COMM_TX_SEQNUM_EN appends a 16-bit sequence-number word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cell_comm_fa_packet_tx #(
  parameter int          FOFB_IDX_WIDTH = 9,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [15:0] MAGIC          = 16'hA5BE
) (
  input  logic                      auroraUserClk,
  input  logic                      auroraUserReset,
  input  logic                      auroraChannelUp,
  input  logic                      faStrobe,
  input  logic                      fofbEnabled,
  input  logic [FOFB_IDX_WIDTH-1:0] fofbIndex,
  input  logic [DATA_WIDTH-1:0]     faX,
  input  logic [DATA_WIDTH-1:0]     faY,
  input  logic [DATA_WIDTH-1:0]     faS,
  output logic                      txTvalid,
  output logic                      txTlast,
  output logic [31:0]               txTdata,
  input  logic                      txTready,
  output logic                      txBusy,
  output logic [31:0]               sentCount,
  output logic [15:0]               overrunCount,
  output logic [15:0]               dropCount,
  output logic [15:0]               abortCount
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_HDR  = 3'd1;
  localparam logic [2:0] c_XW   = 3'd2;
  localparam logic [2:0] c_YW   = 3'd3;
  localparam logic [2:0] c_SW   = 3'd4;
  localparam logic [2:0] c_QW   = 3'd5;

`ifdef CELL_COMM_TX_SEQNUM_EN
  localparam logic [2:0] c_LAST = c_QW;
`else
  localparam logic [2:0] c_LAST = c_SW;
`endif

  logic [2:0]            r_state;
  logic [2:0]            w_stateNext;
  logic [31:0]           r_hdr;
  logic [DATA_WIDTH-1:0] r_faX;
  logic [DATA_WIDTH-1:0] r_faY;
  logic [DATA_WIDTH-1:0] r_faS;
  logic [8:0]            w_idxExt;
  logic                  w_idle;
  logic                  w_start;
  logic                  w_drop;
  logic                  w_overrun;
  logic                  w_abort;
  logic                  w_done;
`ifdef CELL_COMM_TX_SEQNUM_EN
  logic [15:0]           r_seq;
`endif

  assign w_idxExt  = 9'(fofbIndex);
  assign w_idle    = (r_state == c_IDLE);
  assign w_start   = w_idle && faStrobe && auroraChannelUp;
  assign w_drop    = w_idle && faStrobe && !auroraChannelUp;
  assign w_overrun = !w_idle && faStrobe;
  assign w_abort   = !w_idle && !auroraChannelUp;
  assign w_done    = (r_state == c_LAST) && auroraChannelUp && txTready;

  always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
    if (auroraUserReset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Channel loss takes priority over any handshake, including the last beat.
  always_comb begin
    w_stateNext = r_state;
    if (w_idle) begin
      if (w_start) begin
        w_stateNext = c_HDR;
      end
    end else if (!auroraChannelUp) begin
      w_stateNext = c_IDLE;
    end else if (txTready) begin
      case (r_state)
        c_HDR:   w_stateNext = c_XW;
        c_XW:    w_stateNext = c_YW;
        c_YW:    w_stateNext = c_SW;
`ifdef CELL_COMM_TX_SEQNUM_EN
        c_SW:    w_stateNext = c_QW;
        c_QW:    w_stateNext = c_IDLE;
`else
        c_SW:    w_stateNext = c_IDLE;
`endif
        default: w_stateNext = c_IDLE;
      endcase
    end
  end

  always_comb begin
    txTvalid = !w_idle;
    txBusy   = !w_idle;
    txTlast  = (r_state == c_LAST);
    case (r_state)
      c_HDR:   txTdata = r_hdr;
      c_XW:    txTdata = r_faX;
      c_YW:    txTdata = r_faY;
      c_SW:    txTdata = r_faS;
`ifdef CELL_COMM_TX_SEQNUM_EN
      c_QW:    txTdata = {16'h0000, r_seq};
`endif
      default: txTdata = 32'h0000_0000;
    endcase
  end

  // Frame contents are captured once so mid-frame input changes cannot leak in.
  always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
    if (auroraUserReset) begin
      r_hdr <= 32'h0000_0000;
      r_faX <= '0;
      r_faY <= '0;
      r_faS <= '0;
    end else if (w_start) begin
      r_hdr <= {MAGIC, fofbEnabled, 6'b000000, w_idxExt};
      r_faX <= faX;
      r_faY <= faY;
      r_faS <= faS;
    end
  end

  always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
    if (auroraUserReset) begin
      sentCount    <= 32'h0000_0000;
      overrunCount <= 16'h0000;
      dropCount    <= 16'h0000;
      abortCount   <= 16'h0000;
    end else begin
      if (w_done) begin
        sentCount <= sentCount + 32'd1;
      end
      if (w_overrun && (overrunCount != 16'hFFFF)) begin
        overrunCount <= overrunCount + 16'd1;
      end
      if (w_drop && (dropCount != 16'hFFFF)) begin
        dropCount <= dropCount + 16'd1;
      end
      if (w_abort && (abortCount != 16'hFFFF)) begin
        abortCount <= abortCount + 16'd1;
      end
    end
  end

`ifdef CELL_COMM_TX_SEQNUM_EN
  always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
    if (auroraUserReset) begin
      r_seq <= 16'h0000;
    end else if (w_done) begin
      r_seq <= r_seq + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
